// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - condition code and flag types plus the ARM condition evaluator
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // NV is reserved and never executes.
    function automatic logic eval_cond(input cond_e cond, input nzcv_t f);
        logic r;
        case (cond)
            EQ:      r = f.z;
            NE:      r = ~f.z;
            CS:      r = f.c;
            CC:      r = ~f.c;
            MI:      r = f.n;
            PL:      r = ~f.n;
            VS:      r = f.v;
            VC:      r = ~f.v;
            HI:      r = f.c & ~f.z;
            LS:      r = ~f.c | f.z;
            GE:      r = (f.n == f.v);
            LT:      r = (f.n != f.v);
            GT:      r = ~f.z & (f.n == f.v);
            LE:      r = f.z | (f.n != f.v);
            AL:      r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// rtl/cond_eval.sv - combinational condition evaluator on one NZCV context
module cond_eval
    import cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex,
    output logic       cond_undef
);

    always_comb begin
        cond_ex    = eval_cond(cond_e'(cond), nzcv_t'(flags));
        cond_undef = (cond == NV);
    end

endmodule

// File: rtl/cond_flag_unit.sv
// rtl/cond_flag_unit.sv - banked NZCV flags, condition execute and IT-block sequencer
module cond_flag_unit
    import cond_pkg::*;
#(
    parameter  int NUM_BANKS = 2,
    parameter  int IT_MAX    = 4,
    localparam int BW        = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int CW        = $clog2(IT_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              instr_valid,
    input  logic              stall,
    input  logic [3:0]        Cond,
    input  logic [3:0]        ALUFlags,
    input  logic [1:0]        FlagsWrite,
    input  logic [BW-1:0]     bank_sel,
    input  logic              flags_load,
    input  logic [3:0]        flags_load_val,
    input  logic              it_start,
    input  logic [3:0]        it_cond,
    input  logic [CW-1:0]     it_len,
    input  logic [IT_MAX-1:0] it_pattern,
    output logic              CondEx,
    output logic [3:0]        Flags,
    output logic              cond_undef,
    output logic              it_active,
    output logic [CW-1:0]     it_remaining,
    output logic              it_err
);

    logic [3:0]        bank_q [NUM_BANKS];
    logic [3:0]        bank_d [NUM_BANKS];
    logic              it_active_q, it_active_d;
    logic [CW-1:0]     it_rem_q, it_rem_d;
    logic [IT_MAX-1:0] it_pat_q, it_pat_d;
    logic [3:0]        it_cond_q, it_cond_d;
    logic              it_err_q, it_err_d;

    logic       adv;
    logic       bank_ok;
    logic [3:0] cur_flags;
    logic [3:0] eff_cond;
    logic       eval_ex;
    logic       len_ok;

    always_comb begin
        adv       = instr_valid & ~stall;
        bank_ok   = int'(bank_sel) < NUM_BANKS;
        cur_flags = bank_ok ? bank_q[bank_sel] : 4'b0000;
        eff_cond  = it_active_q ? (it_pat_q[0] ? it_cond_q : (it_cond_q ^ 4'b0001)) : Cond;
        len_ok    = (it_len != '0) && (int'(it_len) <= IT_MAX);
    end

    cond_eval u_eval (
        .cond       (eff_cond),
        .flags      (cur_flags),
        .cond_ex    (eval_ex),
        .cond_undef (cond_undef)
    );

    // The IT instruction itself always executes, whatever its own Cond field says.
    assign CondEx       = (it_start & ~it_active_q) | eval_ex;
    assign Flags        = cur_flags;
    assign it_active    = it_active_q;
    assign it_remaining = it_rem_q;
    assign it_err       = it_err_q;

    always_comb begin
        bank_d = bank_q;
        if (adv && bank_ok) begin
            if (flags_load) begin
                bank_d[bank_sel] = flags_load_val;
            end else if (CondEx) begin
                if (FlagsWrite[1]) bank_d[bank_sel][3:2] = ALUFlags[3:2];
                if (FlagsWrite[0]) bank_d[bank_sel][1:0] = ALUFlags[1:0];
            end
        end
    end

    // A rejected IT request leaves the sequencer exactly as it was.
    always_comb begin
        it_active_d = it_active_q;
        it_rem_d    = it_rem_q;
        it_pat_d    = it_pat_q;
        it_cond_d   = it_cond_q;
        it_err_d    = adv & it_start & (it_active_q | ~len_ok);
        if (adv) begin
            if (it_active_q) begin
                if (!it_start) begin
                    it_pat_d    = it_pat_q >> 1;
                    it_rem_d    = it_rem_q - CW'(1);
                    it_active_d = (it_rem_q != CW'(1));
                end
            end else if (it_start && len_ok) begin
                it_active_d = 1'b1;
                it_rem_d    = it_len;
                it_pat_d    = it_pattern;
                it_cond_d   = it_cond;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bank_q      <= '{default: 4'b0000};
            it_active_q <= 1'b0;
            it_rem_q    <= '0;
            it_pat_q    <= '0;
            it_cond_q   <= 4'b0000;
            it_err_q    <= 1'b0;
        end else begin
            bank_q      <= bank_d;
            it_active_q <= it_active_d;
            it_rem_q    <= it_rem_d;
            it_pat_q    <= it_pat_d;
            it_cond_q   <= it_cond_d;
            it_err_q    <= it_err_d;
        end
    end

endmodule

// File: tb/tb_cond_flag_unit.sv
// tb/tb_cond_flag_unit.sv - self-checking bench for cond_flag_unit with a queue-based reference model
module tb_cond_flag_unit;

    localparam int NUM_BANKS = 2;
    localparam int IT_MAX    = 4;
    localparam int CW        = 3;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              instr_valid;
    logic              stall;
    logic [3:0]        Cond;
    logic [3:0]        ALUFlags;
    logic [1:0]        FlagsWrite;
    logic              bank_sel;
    logic              flags_load;
    logic [3:0]        flags_load_val;
    logic              it_start;
    logic [3:0]        it_cond;
    logic [CW-1:0]     it_len;
    logic [IT_MAX-1:0] it_pattern;
    logic              CondEx;
    logic [3:0]        Flags;
    logic              cond_undef;
    logic              it_active;
    logic [CW-1:0]     it_remaining;
    logic              it_err;

    int total = 0;
    int bad   = 0;

    cond_flag_unit #(.NUM_BANKS(NUM_BANKS), .IT_MAX(IT_MAX)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .instr_valid    (instr_valid),
        .stall          (stall),
        .Cond           (Cond),
        .ALUFlags       (ALUFlags),
        .FlagsWrite     (FlagsWrite),
        .bank_sel       (bank_sel),
        .flags_load     (flags_load),
        .flags_load_val (flags_load_val),
        .it_start       (it_start),
        .it_cond        (it_cond),
        .it_len         (it_len),
        .it_pattern     (it_pattern),
        .CondEx         (CondEx),
        .Flags          (Flags),
        .cond_undef     (cond_undef),
        .it_active      (it_active),
        .it_remaining   (it_remaining),
        .it_err         (it_err)
    );

    always #5 clk = ~clk;

    // Reference state: one nibble per bank, and the IT block as a queue of pending conditions.
    logic [3:0] bank_m [NUM_BANKS];
    logic [3:0] itq [$];
    bit         m_err  = 1'b0;
    bit         chk_en = 1'b0;

    function automatic bit ref_eval(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3], z = f[2], cf = f[1], v = f[0], r;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cf;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cf && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return c[0] ? !r : r;
    endfunction

    function automatic logic [3:0] m_ec();
        return (itq.size() > 0) ? itq[0] : Cond;
    endfunction

    function automatic logic [3:0] m_flags();
        return bank_m[bank_sel];
    endfunction

    function automatic bit m_condex();
        if (it_start && itq.size() == 0) return 1'b1;
        return ref_eval(m_ec(), m_flags());
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit adv, cx;
        if (!reset_n) begin
            for (int i = 0; i < NUM_BANKS; i++) bank_m[i] = 4'b0000;
            itq.delete();
            m_err  = 1'b0;
            chk_en = 1'b1;
        end else begin
            adv   = instr_valid && !stall;
            cx    = m_condex();
            m_err = 1'b0;
            if (adv) begin
                if (flags_load) bank_m[bank_sel] = flags_load_val;
                else if (cx) begin
                    if (FlagsWrite[1]) bank_m[bank_sel][3:2] = ALUFlags[3:2];
                    if (FlagsWrite[0]) bank_m[bank_sel][1:0] = ALUFlags[1:0];
                end
                if (itq.size() > 0) begin
                    if (it_start) m_err = 1'b1;
                    else void'(itq.pop_front());
                end else if (it_start) begin
                    if (it_len >= 1 && it_len <= IT_MAX) begin
                        for (int i = 0; i < int'(it_len); i++)
                            itq.push_back(it_pattern[i] ? it_cond : (it_cond ^ 4'b0001));
                    end else m_err = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("condex",    8'(CondEx),       8'(m_condex()));
            chk("undef",     8'(cond_undef),   8'(m_ec() == 4'hF));
            chk("flags",     8'(Flags),        8'(m_flags()));
            chk("active",    8'(it_active),    8'(itq.size() != 0));
            chk("remaining", 8'(it_remaining), 8'(itq.size()));
            chk("err",       8'(it_err),       8'(m_err));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        reset_n = 1'b1; instr_valid = 1'b1; stall = 1'b0;
        Cond = 4'hE; ALUFlags = 4'h0; FlagsWrite = 2'b00; bank_sel = 1'b0;
        flags_load = 1'b0; flags_load_val = 4'h0;
        it_start = 1'b0; it_cond = 4'h0; it_len = '0; it_pattern = '0;
    endtask

    task automatic randomize_inputs(input bit allow_reset);
        reset_n        = allow_reset ? ($urandom_range(0, 99) != 0) : 1'b1;
        instr_valid    = ($urandom_range(0, 9) != 0);
        stall          = ($urandom_range(0, 4) == 0);
        Cond           = 4'($urandom);
        ALUFlags       = 4'($urandom);
        FlagsWrite     = 2'($urandom);
        bank_sel       = 1'($urandom);
        flags_load     = ($urandom_range(0, 9) == 0);
        flags_load_val = 4'($urandom);
        it_start       = ($urandom_range(0, 5) == 0) && (Cond != 4'hF);
        it_cond        = 4'($urandom_range(0, 14));
        it_len         = CW'($urandom_range(0, 7));
        it_pattern     = 4'($urandom);
    endtask

    initial begin
        // Reset with junk inputs
        randomize_inputs(1'b0);
        reset_n = 1'b0;
        tick();
        randomize_inputs(1'b0);
        reset_n = 1'b0;
        tick();
        idle(); reset_n = 1'b0; Cond = 4'h0;
        #1;
        chk("rst_flags", 8'(Flags), 8'h0);
        chk("rst_active", 8'(it_active), 8'h0);
        chk("rst_err", 8'(it_err), 8'h0);
        chk("rst_condex_eq", 8'(CondEx), 8'h0);
        tick();

        // Commit
        idle(); ALUFlags = 4'b1010; FlagsWrite = 2'b10;
        tick();
        Cond = 4'h4; ALUFlags = 4'b0101; FlagsWrite = 2'b11;
        #1;
        chk("commit_nz", 8'(Flags), 8'b1000);
        chk("commit_mi_ex", 8'(CondEx), 8'h1);
        tick();
        Cond = 4'hF; ALUFlags = 4'b1111; FlagsWrite = 2'b11;
        #1;
        chk("commit_nzcv", 8'(Flags), 8'b0101);
        chk("nv_condex", 8'(CondEx), 8'h0);
        chk("nv_undef", 8'(cond_undef), 8'h1);
        tick();
        idle(); instr_valid = 1'b0;
        #1;
        chk("nv_no_write", 8'(Flags), 8'b0101);

        // IT block EQ, len 3, pattern then-else-then
        idle(); flags_load = 1'b1; flags_load_val = 4'b0100;
        tick();
        idle(); it_start = 1'b1; it_cond = 4'h0; it_len = 3'd3; it_pattern = 4'b0101;
        #1;
        chk("it_instr_ex", 8'(CondEx), 8'h1);
        tick();
        idle(); Cond = 4'h1;
        #1;
        chk("it_rem3", 8'(it_remaining), 8'd3);
        chk("it_ex1", 8'(CondEx), 8'h1);
        tick();
        #1;
        chk("it_ex2", 8'(CondEx), 8'h0);
        tick();
        #1;
        chk("it_ex3", 8'(CondEx), 8'h1);
        tick();
        #1;
        chk("it_done", 8'(it_active), 8'h0);

        // Stall and rejects
        idle(); it_start = 1'b1; it_cond = 4'hE; it_len = 3'd4; it_pattern = 4'b1111;
        tick();
        idle(); stall = 1'b1;
        tick();
        #1;
        chk("stall_rem", 8'(it_remaining), 8'd4);
        idle(); it_start = 1'b1; it_len = 3'd2;
        tick();
        #1;
        chk("rej_active_err", 8'(it_err), 8'h1);
        chk("rej_active_rem", 8'(it_remaining), 8'd4);
        idle();
        repeat (4) tick();
        idle(); it_start = 1'b1; it_len = 3'd0;
        tick();
        #1;
        chk("rej_len0_err", 8'(it_err), 8'h1);
        chk("rej_len0_act", 8'(it_active), 8'h0);
        idle(); it_start = 1'b1; it_len = 3'(IT_MAX + 1);
        tick();
        #1;
        chk("rej_big_err", 8'(it_err), 8'h1);
        chk("rej_big_act", 8'(it_active), 8'h0);
        idle();
        tick();
        #1;
        chk("err_pulse_end", 8'(it_err), 8'h0);

        // Banks: load overrides ALU commit, other bank holds
        idle(); bank_sel = 1'b1; flags_load = 1'b1; flags_load_val = 4'b0010;
        ALUFlags = 4'b1111; FlagsWrite = 2'b11;
        tick();
        idle(); bank_sel = 1'b1; instr_valid = 1'b0;
        #1;
        chk("bank1_load", 8'(Flags), 8'b0010);
        bank_sel = 1'b0;
        #1;
        chk("bank0_hold", 8'(Flags), 8'b0100);

        // Reset mid-IT
        idle(); it_start = 1'b1; it_len = 3'd4; it_pattern = 4'b1010;
        tick();
        idle();
        repeat (2) tick();
        #1;
        chk("mid_rem2", 8'(it_remaining), 8'd2);
        idle(); reset_n = 1'b0;
        tick();
        idle(); instr_valid = 1'b0;
        #1;
        chk("mid_rst_act", 8'(it_active), 8'h0);
        chk("mid_rst_b0", 8'(Flags), 8'h0);
        bank_sel = 1'b1;
        #1;
        chk("mid_rst_b1", 8'(Flags), 8'h0);

        // Randomized run against the model
        for (int n = 0; n < 3000; n++) begin
            tick();
            randomize_inputs(1'b1);
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
